muntjac_fpu_round_pack: RTL and testbench

- Back end of the FPU arithmetic datapath: consumes the unrounded, unpacked result produced by the mul/add/fused-multiply-add units.
- Rounds that result, handles denormals, overflow and NaN, packs it into IEEE-754 binary32/64 encoding, and produces RISC-V fflags.
- Two-stage valid/ready pipeline sitting between the FMA datapath and the FP writeback/CSR stage.

---
 rtl/muntjac_fpu_round_pack.sv | 232 +++++++++++++++++++++++
 tb/tb_muntjac_fpu_round_pack.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muntjac_fpu_round_pack.sv
// ============================================================================
// Module   : muntjac_fpu_round_pack
// Purpose  : FPU back end. Rounds the unpacked result produced by the
//            mul/add/FMA units, handles subnormals, overflow and special
//            values, packs it as IEEE-754 and produces RISC-V fflags.
//            Two-stage valid/ready pipeline with full throughput.
// Ports    : clk_i/rst_ni (async active-low), flush_i drops in-flight work.
//            req_*  : unrounded sign/exponent/significand, class flags, mode.
//            resp_* : packed value and {NV, DZ, OF, UF, NX}.
// Options  : MUNTJAC_FPU_ROUND_NANBOX_EN - resp_value_o is 64 bits wide with
//            the bits above the IEEE encoding driven to ones (NaN-boxing).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package muntjac_fpu_pkg;
  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100
  } rounding_mode_e;
endpackage

module muntjac_fpu_round_pack
  import muntjac_fpu_pkg::*;
#(
  parameter int IeeeExpWidth = 8,
  parameter int IeeeSigWidth = 23,
  parameter int InExpWidth   = 10,
  parameter int InSigWidth   = 26
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          flush_i,
  input  logic                          req_valid_i,
  output logic                          req_ready_o,
  input  rounding_mode_e                req_rounding_mode_i,
  input  logic                          req_invalid_operation_i,
  input  logic                          req_sign_i,
  input  logic signed [InExpWidth-1:0]  req_exponent_i,
  input  logic [InSigWidth-1:0]         req_significand_i,
  input  logic                          req_is_zero_i,
  input  logic                          req_is_inf_i,
  input  logic                          req_is_nan_i,
  output logic                          resp_valid_o,
  input  logic                          resp_ready_i,
`ifdef MUNTJAC_FPU_ROUND_NANBOX_EN
  output logic [63:0]                   resp_value_o,
`else
  output logic [IeeeExpWidth+IeeeSigWidth:0] resp_value_o,
`endif
  output logic [4:0]                    resp_flags_o
);

  localparam int IEEE_W    = 1 + IeeeExpWidth + IeeeSigWidth;
  localparam int XW        = InExpWidth + 1;  // headroom for bias and carry
  localparam int BIAS      = 2 ** (IeeeExpWidth - 1) - 1;
  localparam int EMIN      = 1 - BIAS;
  localparam int MAX_SHIFT = IeeeSigWidth + 3;
  localparam int SHW       = $clog2(MAX_SHIFT + 1);
  localparam logic signed [XW-1:0] EMIN_X      = XW'(EMIN);
  localparam logic signed [XW-1:0] BIAS_X      = XW'(BIAS);
  localparam logic signed [XW-1:0] MAX_SHIFT_X = XW'(MAX_SHIFT);
  localparam logic signed [XW-1:0] EXP_ONES_X  = XW'(2 ** IeeeExpWidth - 1);

  function automatic logic round_inc(input rounding_mode_e rm, input logic sgn,
                                     input logic lsb, input logic g, input logic s);
    case (rm)
      RNE:     round_inc = g & (s | lsb);
      RTZ:     round_inc = 1'b0;
      RDN:     round_inc = sgn & (g | s);
      RUP:     round_inc = ~sgn & (g | s);
      RMM:     round_inc = g;
      default: round_inc = 1'b0;
    endcase
  endfunction

  // Handshake
  logic r_s1_valid, r_s2_valid;
  logic w_s1_adv, w_s2_adv;
  assign w_s2_adv    = ~r_s2_valid | resp_ready_i;
  assign w_s1_adv    = ~r_s1_valid | w_s2_adv;
  assign req_ready_o = w_s1_adv;

  // ---------------- Stage 1: denormal shift and round decision -------------
  logic signed [XW-1:0]  w_exp_x, w_shift_full;
  logic                  w_tiny_exp, w_lost, w_inc, w_inc_full, w_tiny;
  logic [SHW-1:0]        w_shamt;
  logic [InSigWidth-1:0] w_shifted, w_mag;

  assign w_exp_x      = {req_exponent_i[InExpWidth-1], req_exponent_i};
  assign w_tiny_exp   = w_exp_x < EMIN_X;
  assign w_shift_full = EMIN_X - w_exp_x;

  always_comb begin
    w_shamt = '0;
    if (w_tiny_exp) begin
      if (w_shift_full > MAX_SHIFT_X) w_shamt = SHW'(MAX_SHIFT);
      else                            w_shamt = w_shift_full[SHW-1:0];
    end
    w_lost = 1'b0;
    for (int i = 0; i < InSigWidth; i++) begin
      if (i < int'(w_shamt)) w_lost = w_lost | req_significand_i[i];
    end
    w_shifted = req_significand_i >> w_shamt;
    w_mag     = {w_shifted[InSigWidth-1:1], w_shifted[0] | w_lost};
  end

  assign w_inc = round_inc(req_rounding_mode_i, req_sign_i, w_mag[2], w_mag[1], w_mag[0]);

  // Tininess after rounding: with an unbounded exponent, a tiny value only
  // reaches 2^emin when it sits one binade below with an all-ones fraction
  // and rounds up at full precision.
  assign w_inc_full = round_inc(req_rounding_mode_i, req_sign_i, req_significand_i[2],
                                req_significand_i[1], req_significand_i[0]);
  assign w_tiny = w_tiny_exp &
                  ~((w_exp_x == EMIN_X - XW'(1)) & (&req_significand_i[InSigWidth-2:2]) &
                    w_inc_full);

  logic                  r_s1_sign, r_s1_inc, r_s1_nx, r_s1_tiny, r_s1_nv;
  logic                  r_s1_zero, r_s1_inf, r_s1_nan;
  logic signed [XW-1:0]  r_s1_exp;
  logic [IeeeSigWidth:0] r_s1_mant;
  rounding_mode_e        r_s1_mode;

  // ---------------- Stage 2: increment and pack ----------------------------
  logic [IeeeSigWidth+1:0]   w_sum;
  logic signed [XW-1:0]      w_bexp, w_bexp_f;
  logic [IeeeSigWidth-1:0]   w_frac;
  logic                      w_of, w_nx, w_max_finite;
  logic [IEEE_W-1:0]         w_value;
  logic [4:0]                w_flags;

  assign w_sum  = {1'b0, r_s1_mant} + (IeeeSigWidth + 2)'(r_s1_inc);
  assign w_bexp = r_s1_exp + BIAS_X;

  always_comb begin
    w_bexp_f = '0;
    w_frac   = w_sum[IeeeSigWidth-1:0];
    if (w_sum[IeeeSigWidth+1]) begin
      w_bexp_f = w_bexp + XW'(1);
      w_frac   = '0;
    end else if (w_sum[IeeeSigWidth]) begin
      // Also covers a subnormal rounding up into the minimum normal.
      w_bexp_f = w_bexp;
    end
  end

  assign w_of = w_bexp_f >= EXP_ONES_X;
  assign w_nx = r_s1_nx | w_of;
  assign w_max_finite = (r_s1_mode == RTZ) | ((r_s1_mode == RDN) & ~r_s1_sign) |
                        ((r_s1_mode == RUP) & r_s1_sign);

  always_comb begin
    w_value = {r_s1_sign, w_bexp_f[IeeeExpWidth-1:0], w_frac};
    w_flags = {r_s1_nv, 1'b0, w_of, r_s1_tiny & w_nx, w_nx};
    if (r_s1_nan) begin
      w_value = {1'b0, {IeeeExpWidth{1'b1}}, 1'b1, {(IeeeSigWidth-1){1'b0}}};
      w_flags = {r_s1_nv, 4'b0000};
    end else if (r_s1_inf) begin
      w_value = {r_s1_sign, {IeeeExpWidth{1'b1}}, {IeeeSigWidth{1'b0}}};
      w_flags = {r_s1_nv, 4'b0000};
    end else if (r_s1_zero) begin
      w_value = {r_s1_sign, {(IEEE_W-1){1'b0}}};
      w_flags = {r_s1_nv, 4'b0000};
    end else if (w_of) begin
      if (w_max_finite)
        w_value = {r_s1_sign, {(IeeeExpWidth-1){1'b1}}, 1'b0, {IeeeSigWidth{1'b1}}};
      else
        w_value = {r_s1_sign, {IeeeExpWidth{1'b1}}, {IeeeSigWidth{1'b0}}};
    end
  end

  logic [IEEE_W-1:0] r_s2_value;
  logic [4:0]        r_s2_flags;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_s1_valid <= 1'b0;
      r_s1_sign  <= 1'b0;
      r_s1_inc   <= 1'b0;
      r_s1_nx    <= 1'b0;
      r_s1_tiny  <= 1'b0;
      r_s1_nv    <= 1'b0;
      r_s1_zero  <= 1'b0;
      r_s1_inf   <= 1'b0;
      r_s1_nan   <= 1'b0;
      r_s1_exp   <= '0;
      r_s1_mant  <= '0;
      r_s1_mode  <= RNE;
      r_s2_valid <= 1'b0;
      r_s2_value <= '0;
      r_s2_flags <= '0;
    end else begin
      if (flush_i)       r_s1_valid <= 1'b0;
      else if (w_s1_adv) r_s1_valid <= req_valid_i;
      if (w_s1_adv && req_valid_i) begin
        r_s1_sign <= req_sign_i;
        r_s1_inc  <= w_inc;
        r_s1_nx   <= w_mag[1] | w_mag[0];
        r_s1_tiny <= w_tiny;
        r_s1_nv   <= req_invalid_operation_i;
        r_s1_zero <= req_is_zero_i;
        r_s1_inf  <= req_is_inf_i;
        r_s1_nan  <= req_is_nan_i;
        r_s1_exp  <= w_tiny_exp ? EMIN_X : w_exp_x;
        r_s1_mant <= w_mag[InSigWidth-1:2];
        r_s1_mode <= req_rounding_mode_i;
      end

      if (flush_i)       r_s2_valid <= 1'b0;
      else if (w_s2_adv) r_s2_valid <= r_s1_valid;
      if (w_s2_adv && r_s1_valid) begin
        r_s2_value <= w_value;
        r_s2_flags <= w_flags;
      end
    end
  end

  assign resp_valid_o = r_s2_valid;
  assign resp_flags_o = r_s2_flags;
`ifdef MUNTJAC_FPU_ROUND_NANBOX_EN
  assign resp_value_o = {{(64-IEEE_W){1'b1}}, r_s2_value};
`else
  assign resp_value_o = r_s2_value;
`endif

endmodule

`default_nettype wire

// File: tb/tb_muntjac_fpu_round_pack.sv
// ============================================================================
// Module   : tb_muntjac_fpu_round_pack
// Purpose  : Self-checking bench for muntjac_fpu_round_pack (binary32 build).
//            Directed vectors push expected results into a scoreboard queue;
//            a monitor pops and compares on every output transfer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_muntjac_fpu_round_pack;
  import muntjac_fpu_pkg::*;

`ifdef MUNTJAC_FPU_ROUND_NANBOX_EN
  localparam int OW = 64;
`else
  localparam int OW = 32;
`endif

  logic                clk_i = 1'b0;
  logic                rst_ni = 1'b0;
  logic                flush_i = 1'b0;
  logic                req_valid_i = 1'b0;
  logic                req_ready_o;
  rounding_mode_e      req_rounding_mode_i = RNE;
  logic                req_invalid_operation_i = 1'b0;
  logic                req_sign_i = 1'b0;
  logic signed [9:0]   req_exponent_i = '0;
  logic [25:0]         req_significand_i = '0;
  logic                req_is_zero_i = 1'b0;
  logic                req_is_inf_i = 1'b0;
  logic                req_is_nan_i = 1'b0;
  logic                resp_valid_o;
  logic                resp_ready_i = 1'b0;
  logic [OW-1:0]       resp_value_o;
  logic [4:0]          resp_flags_o;

  muntjac_fpu_round_pack dut (
    .clk_i                   (clk_i),
    .rst_ni                  (rst_ni),
    .flush_i                 (flush_i),
    .req_valid_i             (req_valid_i),
    .req_ready_o             (req_ready_o),
    .req_rounding_mode_i     (req_rounding_mode_i),
    .req_invalid_operation_i (req_invalid_operation_i),
    .req_sign_i              (req_sign_i),
    .req_exponent_i          (req_exponent_i),
    .req_significand_i       (req_significand_i),
    .req_is_zero_i           (req_is_zero_i),
    .req_is_inf_i            (req_is_inf_i),
    .req_is_nan_i            (req_is_nan_i),
    .resp_valid_o            (resp_valid_o),
    .resp_ready_i            (resp_ready_i),
    .resp_value_o            (resp_value_o),
    .resp_flags_o            (resp_flags_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] value;
    logic [4:0]  flags;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [4:0] F_NX = 5'b00001, F_UF = 5'b00010, F_OF = 5'b00100, F_NV = 5'b10000;

  function automatic logic [OW-1:0] ext(input logic [31:0] v);
    logic [63:0] t;
    t = {32'hFFFF_FFFF, v};
    return t[OW-1:0];
  endfunction

  // Monitor: compares on every output transfer
  always @(negedge clk_i) begin
    if (rst_ni && resp_valid_o && resp_ready_i) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_resp got value=%h flags=%b, required no response", resp_value_o, resp_flags_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (resp_value_o !== ext(e.value)) begin
          errors++;
          $display("FAIL value got %h required %h", resp_value_o, ext(e.value));
        end
        checks++;
        if (resp_flags_o !== e.flags) begin
          errors++;
          $display("FAIL flags got %b required %b (value %h)", resp_flags_o, e.flags, e.value);
        end
        if (e.lat) begin
          checks++;
          if (cyc != e.acc + 2) begin
            errors++;
            $display("FAIL latency got %0d cycles required 2", cyc - e.acc);
          end
        end
      end
    end
  end

  task automatic drive(input logic sgn, input int e, input logic [25:0] m, input rounding_mode_e rm,
                       input logic nv, input logic z, input logic inf, input logic nan);
    req_valid_i             = 1'b1;
    req_sign_i              = sgn;
    req_exponent_i          = 10'(e);
    req_significand_i       = m;
    req_rounding_mode_i     = rm;
    req_invalid_operation_i = nv;
    req_is_zero_i           = z;
    req_is_inf_i            = inf;
    req_is_nan_i            = nan;
  endtask

  // Issue one request (caller is just after a rising edge); push expectation on accept.
  task automatic send(input logic sgn, input int e, input logic [25:0] m, input rounding_mode_e rm,
                      input logic nv, input logic z, input logic inf, input logic nan,
                      input logic [31:0] ev, input logic [4:0] ef, input bit lat);
    int n;
    exp_t x;
    n = 0;
    drive(sgn, e, m, rm, nv, z, inf, nan);
    @(negedge clk_i);
    while (!req_ready_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    if (!req_ready_o) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout got ready=0 required ready=1 within 50 cycles");
    end else begin
      x.value = ev; x.flags = ef; x.acc = cyc; x.lat = lat;
      sb.push_back(x);
    end
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
  endtask

  task automatic expect_bit(input string name, input logic got, input logic req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got %b required %b", name, got, req);
    end
  endtask

  task automatic drain;
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk_i);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d outstanding required 0", sb.size());
    end
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    expect_bit("reset_valid", resp_valid_o, 1'b0);
    checks++;
    if (resp_value_o !== '0 || resp_flags_o !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs got value=%h flags=%b required 0/0", resp_value_o, resp_flags_o);
    end
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(negedge clk_i);
    expect_bit("ready_after_reset", req_ready_o, 1'b1);
    @(posedge clk_i); #1;
    resp_ready_i = 1'b1;

    //    sgn  exp   sig          mode nv z i n  expected      flags        lat
    send(1'b0,    0, 26'h2000000, RNE, 0,0,0,0, 32'h3F800000, 5'b0,        1);
    send(1'b0,    0, 26'h3FFFFFE, RNE, 0,0,0,0, 32'h40000000, F_NX,        0);
    send(1'b0,  128, 26'h2000000, RNE, 0,0,0,0, 32'h7F800000, F_OF|F_NX,   0);
    send(1'b0,  128, 26'h2000000, RTZ, 0,0,0,0, 32'h7F7FFFFF, F_OF|F_NX,   0);
    send(1'b1,  128, 26'h2000000, RUP, 0,0,0,0, 32'hFF7FFFFF, F_OF|F_NX,   0);
    send(1'b1,  128, 26'h2000000, RDN, 0,0,0,0, 32'hFF800000, F_OF|F_NX,   0);
    send(1'b0,  127, 26'h3FFFFFE, RNE, 0,0,0,0, 32'h7F800000, F_OF|F_NX,   0);
    send(1'b0, -127, 26'h2000000, RNE, 0,0,0,0, 32'h00400000, 5'b0,        0);
    send(1'b0, -150, 26'h2000000, RNE, 0,0,0,0, 32'h00000000, F_UF|F_NX,   0);
    send(1'b0, -150, 26'h2000000, RUP, 0,0,0,0, 32'h00000001, F_UF|F_NX,   0);
    send(1'b0, -127, 26'h3FFFFFE, RNE, 0,0,0,0, 32'h00800000, F_NX,        0);
    send(1'b0, -126, 26'h2000000, RNE, 0,0,0,0, 32'h00800000, 5'b0,        0);
    send(1'b0,    1, 26'h2000002, RMM, 0,0,0,0, 32'h40000001, F_NX,        0);
    send(1'b0,    1, 26'h2000002, RNE, 0,0,0,0, 32'h40000000, F_NX,        0);
    send(1'b1,    0, 26'h2000001, RDN, 0,0,0,0, 32'hBF800001, F_NX,        0);
    send(1'b1,    0, 26'h2000001, RUP, 0,0,0,0, 32'hBF800000, F_NX,        0);
    send(1'b1,    5, 26'h2000000, RNE, 1,0,0,1, 32'h7FC00000, F_NV,        0);
    send(1'b1,    5, 26'h2000000, RNE, 0,0,1,0, 32'hFF800000, 5'b0,        0);
    send(1'b1,    5, 26'h2000000, RNE, 1,1,0,0, 32'h80000000, F_NV,        0);
    drain();

    // Back-to-back with a stalled consumer
    resp_ready_i = 1'b0;
    fork
      begin
        send(1'b0, 0, 26'h2000000, RNE, 0,0,0,0, 32'h3F800000, 5'b0, 0);
        send(1'b0, 1, 26'h2000000, RNE, 0,0,0,0, 32'h40000000, 5'b0, 0);
        send(1'b0, 2, 26'h2000000, RNE, 0,0,0,0, 32'h40800000, 5'b0, 0);
        send(1'b1, 0, 26'h2000000, RNE, 0,0,0,0, 32'hBF800000, 5'b0, 0);
      end
      begin
        int n;
        n = 0;
        while (!resp_valid_o && n < 20) begin
          @(negedge clk_i);
          n++;
        end
        expect_bit("stall_valid", resp_valid_o, 1'b1);
        repeat (3) begin
          expect_bit("stall_ready_low", req_ready_o, 1'b0);
          checks++;
          if (resp_value_o !== ext(32'h3F800000) || resp_flags_o !== 5'b0) begin
            errors++;
            $display("FAIL stall_hold got %h/%b required %h/00000", resp_value_o, resp_flags_o,
                     ext(32'h3F800000));
          end
          @(negedge clk_i);
        end
        @(posedge clk_i); #1;
        resp_ready_i = 1'b1;
      end
    join
    drain();

    // Flush with both stages full, plus a request arriving alongside the flush
    resp_ready_i = 1'b0;
    send(1'b0, 3, 26'h2000000, RNE, 0,0,0,0, 32'h41000000, 5'b0, 0);
    send(1'b0, 4, 26'h2000000, RNE, 0,0,0,0, 32'h41800000, 5'b0, 0);
    expect_bit("full_before_flush", resp_valid_o, 1'b1);
    flush_i = 1'b1;
    drive(1'b0, 6, 26'h2000000, RNE, 0,0,0,0);
    @(posedge clk_i); #1;
    flush_i     = 1'b0;
    req_valid_i = 1'b0;
    sb.delete();
    expect_bit("flush_valid", resp_valid_o, 1'b0);
    resp_ready_i = 1'b1;
    repeat (4) @(posedge clk_i);
    #1;
    expect_bit("flush_no_output", resp_valid_o, 1'b0);
    send(1'b0, 0, 26'h2000000, RNE, 0,0,0,0, 32'h3F800000, 5'b0, 1);
    drain();

    // Asynchronous reset mid-stream
    resp_ready_i = 1'b0;
    send(1'b0, 3, 26'h2000000, RNE, 0,0,0,0, 32'h41000000, 5'b0, 0);
    send(1'b0, 4, 26'h2000000, RNE, 0,0,0,0, 32'h41800000, 5'b0, 0);
    #2;
    rst_ni = 1'b0;
    #1;
    expect_bit("async_reset_valid", resp_valid_o, 1'b0);
    checks++;
    if (resp_value_o !== '0 || resp_flags_o !== 5'b0) begin
      errors++;
      $display("FAIL async_reset_outputs got %h/%b required 0/00000", resp_value_o, resp_flags_o);
    end
    sb.delete();
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    resp_ready_i = 1'b1;
    send(1'b0, -150, 26'h2000000, RUP, 0,0,0,0, 32'h00000001, F_UF|F_NX, 1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
